// File: rtl/apb_master_mux_pkg.sv
// Shared types and sizing helpers for the APB requester and its address decoder.
package apb_master_mux_pkg;

    // Requester FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    // Why a response carries rsp_err (CAUSE_NONE means a clean completion).
    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_SLVERR  = 2'd1,
        CAUSE_DECODE  = 2'd2,
        CAUSE_TIMEOUT = 2'd3
    } err_cause_t;

    // Width of the slave index field: max(1, clog2(n)).
    function automatic int idx_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    // Width of the ACCESS wait counter: max(1, clog2(t+1)).
    function automatic int cnt_width(input int t);
        return ($clog2(t + 1) < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/apb_master_mux_if.sv
// Command, response and APB bus signals of the requester, bundled as one interface.
//
// Handshake rule for both cmd_* and rsp_* channels: a beat transfers on a
// rising pclk edge where valid & ready are both 1; the producer holds valid
// and its payload stable until that edge, and ready may be asserted
// independently of valid.
interface apb_master_mux_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4
);
    // Command channel
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [DATA_W-1:0]     cmd_wdata;
    logic [DATA_W/8-1:0]   cmd_strb;

    // Response channel
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    // APB fabric
    logic [NUM_SLAVES-1:0] psel;
    logic                  penable;
    logic [ADDR_W-1:0]     paddr;
    logic                  pwrite;
    logic [DATA_W-1:0]     pwdata;
    logic [DATA_W/8-1:0]   pstrb;
    logic [DATA_W-1:0]     prdata;
    logic                  pready;
    logic                  pslverr;

    // Requester view.
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  rsp_ready,
        input  prdata, pready, pslverr,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output psel, penable, paddr, pwrite, pwdata, pstrb
    );

    // Environment view: command source, response sink and slave fabric.
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output rsp_ready,
        output prdata, pready, pslverr,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  psel, penable, paddr, pwrite, pwdata, pstrb
    );
endinterface

// File: rtl/apb_master_mux_decode.sv
// Slave decoder: turns the slave-index field of the command address into a
// one-hot select vector and flags indices with no slave behind them.
module apb_addr_decode
    import apb_master_mux_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int IDX_W      = idx_width(NUM_SLAVES)
) (
    input  logic [IDX_W-1:0]      slv_field,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  miss
);

    // One select line per existing slave; a miss leaves all lines low.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel[i] = (slv_field == IDX_W'(i));
        end
    end

    assign miss = (32'(slv_field) >= 32'(NUM_SLAVES));

endmodule

// File: rtl/apb_master_mux.sv
// APB4 requester: accepts one command at a time, selects a slave from the
// upper address bits, runs SETUP/ACCESS with wait states and an optional
// pready timeout, and returns the result on the response channel.
// The interface instance must be built with the same ADDR_W/DATA_W/NUM_SLAVES.
// DATA_W must be 8, 16 or 32; NUM_SLAVES 1..16.
module apb_master_mux
    import apb_master_mux_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SLV_SHIFT  = 12,
    parameter int TIMEOUT    = 16
) (
    input  logic             pclk,
    input  logic             preset_n,
    apb_master_mux_if.master bus,
    output apb_state_t       state_dbg
);

    localparam int IDX_W  = idx_width(NUM_SLAVES);
    localparam int CNT_W  = cnt_width(TIMEOUT);
    localparam int STRB_W = DATA_W / 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    apb_state_t            state_q, state_d;
    logic                  wr_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [STRB_W-1:0]     strb_q;
    logic [NUM_SLAVES-1:0] sel_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_W-1:0]     rdata_q;
    err_cause_t            cause_q;

    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  dec_miss;
    logic                  timeout_hit;
    logic                  in_xfer;

    apb_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .IDX_W      (IDX_W)
    ) u_decode (
        .slv_field (bus.cmd_addr[SLV_SHIFT +: IDX_W]),
        .sel       (dec_sel),
        .miss      (dec_miss)
    );

    // Abort on the ACCESS cycle that would be the TIMEOUT-th without pready.
    assign timeout_hit = (TIMEOUT != 0) && (state_q == ACCESS) &&
                         !bus.pready && (cnt_q == CNT_LAST);

    // State register; reset drops any transfer in flight without a response.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic; a decode miss skips the APB phases entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.cmd_valid) state_d = dec_miss ? RESP : SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (bus.pready || timeout_hit) state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command capture, wait counting and response capture.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        wr_q    <= bus.cmd_write;
                        addr_q  <= bus.cmd_addr;
                        // Reads carry no write data or strobes onto the bus.
                        wdata_q <= bus.cmd_write ? bus.cmd_wdata : '0;
                        strb_q  <= bus.cmd_write ? bus.cmd_strb  : '0;
                        sel_q   <= dec_miss ? '0 : dec_sel;
                        cnt_q   <= '0;
                        rdata_q <= '0;
                        cause_q <= dec_miss ? CAUSE_DECODE : CAUSE_NONE;
                    end
                end
                ACCESS: begin
                    if (bus.pready) begin
                        rdata_q <= (!wr_q && !bus.pslverr) ? bus.prdata : '0;
                        cause_q <= bus.pslverr ? CAUSE_SLVERR : CAUSE_NONE;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        cause_q <= CAUSE_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_xfer = (state_q == SETUP) || (state_q == ACCESS);

    // APB outputs are zero whenever no transfer is on the bus.
    assign bus.psel    = in_xfer ? sel_q   : '0;
    assign bus.penable = (state_q == ACCESS);
    assign bus.paddr   = in_xfer ? addr_q  : '0;
    assign bus.pwrite  = in_xfer && wr_q;
    assign bus.pwdata  = in_xfer ? wdata_q : '0;
    assign bus.pstrb   = in_xfer ? strb_q  : '0;

    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_rdata   = (state_q == RESP) ? rdata_q : '0;
    assign bus.rsp_err     = (state_q == RESP) && (cause_q != CAUSE_NONE);
    assign bus.rsp_timeout = (state_q == RESP) && (cause_q == CAUSE_TIMEOUT);

    assign state_dbg = state_q;

endmodule

// File: tb/tb_apb_master_mux.sv
// Directed bench for apb_master_mux: a 4-slave instance with TIMEOUT=16 and a
// 3-slave instance for the decode-miss case.
module tb_apb_master_mux;
    import apb_master_mux_pkg::*;

    logic       pclk;
    logic       preset_n;
    apb_state_t state4;
    apb_state_t state3;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;
    int acc_cycles;

    apb_master_mux_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(4)) bus4 ();
    apb_master_mux_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(3)) bus3 ();

    apb_master_mux #(
        .ADDR_W(32), .DATA_W(32), .NUM_SLAVES(4), .SLV_SHIFT(12), .TIMEOUT(16)
    ) u_dut (
        .pclk      (pclk),
        .preset_n  (preset_n),
        .bus       (bus4),
        .state_dbg (state4)
    );

    apb_master_mux #(
        .ADDR_W(32), .DATA_W(32), .NUM_SLAVES(3), .SLV_SHIFT(12), .TIMEOUT(16)
    ) u_dut3 (
        .pclk      (pclk),
        .preset_n  (preset_n),
        .bus       (bus3),
        .state_dbg (state3)
    );

    // Clock and reset
    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    task automatic tick();
        @(negedge pclk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        preset_n = 1'b0;
        bus4.cmd_valid = 0; bus4.cmd_write = 0; bus4.cmd_addr = '0;
        bus4.cmd_wdata = '0; bus4.cmd_strb = '0; bus4.rsp_ready = 1;
        bus4.prdata = '0; bus4.pready = 0; bus4.pslverr = 0;
        bus3.cmd_valid = 0; bus3.cmd_write = 0; bus3.cmd_addr = '0;
        bus3.cmd_wdata = '0; bus3.cmd_strb = '0; bus3.rsp_ready = 1;
        bus3.prdata = '0; bus3.pready = 0; bus3.pslverr = 0;

        tick(); tick();
        // Reset state
        chk("rst_state",     state4, IDLE);
        chk("rst_cmd_ready", bus4.cmd_ready, 1);
        chk("rst_rsp_valid", bus4.rsp_valid, 0);
        chk("rst_rsp_err",   bus4.rsp_err, 0);
        chk("rst_psel",      bus4.psel, 0);
        chk("rst_penable",   bus4.penable, 0);
        chk("rst_paddr",     bus4.paddr, 0);
        chk("rst_pwdata",    bus4.pwdata, 0);
        chk("rst_pstrb",     bus4.pstrb, 0);
        chk("rst_pwrite",    bus4.pwrite, 0);
        chk("rst_rdata",     bus4.rsp_rdata, 0);
        preset_n = 1'b1;
        tick();

        // Write, no wait state
        bus4.cmd_valid = 1; bus4.cmd_write = 1; bus4.cmd_addr = 32'h0000_1004;
        bus4.cmd_wdata = 32'hDEAD_BEEF; bus4.cmd_strb = 4'hF; bus4.pready = 1;
        chk("wr_cmd_ready", bus4.cmd_ready, 1);
        tick();
        bus4.cmd_valid = 0;
        chk("wr_setup_psel",    bus4.psel, 4'b0010);
        chk("wr_setup_penable", bus4.penable, 0);
        chk("wr_setup_paddr",   bus4.paddr, 32'h0000_1004);
        chk("wr_setup_pwdata",  bus4.pwdata, 32'hDEAD_BEEF);
        chk("wr_setup_pstrb",   bus4.pstrb, 4'hF);
        chk("wr_setup_pwrite",  bus4.pwrite, 1);
        chk("wr_setup_cmd_rdy", bus4.cmd_ready, 0);
        tick();
        chk("wr_acc_psel",    bus4.psel, 4'b0010);
        chk("wr_acc_penable", bus4.penable, 1);
        chk("wr_acc_rsp_vld", bus4.rsp_valid, 0);
        tick();
        chk("wr_rsp_valid", bus4.rsp_valid, 1);
        chk("wr_rsp_err",   bus4.rsp_err, 0);
        chk("wr_rsp_rdata", bus4.rsp_rdata, 0);
        chk("wr_rsp_psel",  bus4.psel, 0);
        chk("wr_rsp_paddr", bus4.paddr, 0);
        tick();
        chk("wr_idle_rsp_valid", bus4.rsp_valid, 0);
        chk("wr_idle_cmd_ready", bus4.cmd_ready, 1);

        // Read with 3 wait states
        bus4.cmd_valid = 1; bus4.cmd_write = 0; bus4.cmd_addr = 32'h0000_3010;
        bus4.cmd_wdata = 32'hFFFF_FFFF; bus4.cmd_strb = 4'hF; bus4.pready = 0;
        tick();
        bus4.cmd_valid = 0;
        chk("rd_setup_psel",   bus4.psel, 4'b1000);
        chk("rd_setup_pwrite", bus4.pwrite, 0);
        chk("rd_setup_pstrb",  bus4.pstrb, 0);
        chk("rd_setup_pwdata", bus4.pwdata, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rd_acc_psel",    bus4.psel, 4'b1000);
            chk("rd_acc_penable", bus4.penable, 1);
            chk("rd_acc_paddr",   bus4.paddr, 32'h0000_3010);
            chk("rd_acc_pstrb",   bus4.pstrb, 0);
            chk("rd_acc_rsp_vld", bus4.rsp_valid, 0);
            if (i == 3) begin
                bus4.pready = 1; bus4.prdata = 32'h1234_5678;
            end
        end
        tick();
        bus4.prdata = 32'h0BAD_0BAD;
        chk("rd_rsp_valid", bus4.rsp_valid, 1);
        chk("rd_rsp_rdata", bus4.rsp_rdata, 32'h1234_5678);
        chk("rd_rsp_err",   bus4.rsp_err, 0);
        chk("rd_rsp_psel",  bus4.psel, 0);
        tick();

        // pslverr on read, with response backpressure
        bus4.cmd_valid = 1; bus4.cmd_write = 0; bus4.cmd_addr = 32'h0000_0000;
        bus4.pready = 1; bus4.pslverr = 1; bus4.prdata = 32'hAAAA_5555;
        bus4.rsp_ready = 0;
        tick();
        bus4.cmd_valid = 0;
        chk("se_setup_psel", bus4.psel, 4'b0001);
        tick();
        chk("se_acc_penable", bus4.penable, 1);
        tick();
        bus4.pslverr = 0; bus4.pready = 0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid",   bus4.rsp_valid, 1);
            chk("bp_rsp_err",     bus4.rsp_err, 1);
            chk("bp_rsp_timeout", bus4.rsp_timeout, 0);
            chk("bp_rsp_rdata",   bus4.rsp_rdata, 0);
            chk("bp_cmd_ready",   bus4.cmd_ready, 0);
            chk("bp_psel",        bus4.psel, 0);
            tick();
        end
        chk("bp_state", state4, RESP);
        bus4.rsp_ready = 1;
        tick();
        chk("bp_release_rsp_valid", bus4.rsp_valid, 0);
        chk("bp_release_cmd_ready", bus4.cmd_ready, 1);

        // Timeout: pready never rises
        bus4.cmd_valid = 1; bus4.cmd_write = 0; bus4.cmd_addr = 32'h0000_2000;
        bus4.pready = 0;
        tick();
        bus4.cmd_valid = 0;
        acc_cycles = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus4.penable === 1'b1 && bus4.psel === 4'b0100) acc_cycles++;
        end
        chk("to_access_cycles", 64'(acc_cycles), 16);
        tick();
        chk("to_rsp_valid",   bus4.rsp_valid, 1);
        chk("to_rsp_err",     bus4.rsp_err, 1);
        chk("to_rsp_timeout", bus4.rsp_timeout, 1);
        chk("to_rsp_rdata",   bus4.rsp_rdata, 0);
        chk("to_psel",        bus4.psel, 0);
        chk("to_penable",     bus4.penable, 0);
        tick();
        chk("to_idle_timeout", bus4.rsp_timeout, 0);

        // Decode miss on the 3-slave instance
        bus3.cmd_valid = 1; bus3.cmd_write = 1; bus3.cmd_addr = 32'h0000_3000;
        bus3.cmd_wdata = 32'h1111_2222; bus3.cmd_strb = 4'h3;
        chk("miss_cmd_ready", bus3.cmd_ready, 1);
        tick();
        bus3.cmd_valid = 0;
        chk("miss_rsp_valid",   bus3.rsp_valid, 1);
        chk("miss_rsp_err",     bus3.rsp_err, 1);
        chk("miss_rsp_timeout", bus3.rsp_timeout, 0);
        chk("miss_rsp_rdata",   bus3.rsp_rdata, 0);
        chk("miss_psel",        bus3.psel, 0);
        chk("miss_penable",     bus3.penable, 0);
        tick();
        chk("miss_idle_rsp_valid", bus3.rsp_valid, 0);
        // Highest existing slave on the 3-slave instance still decodes
        bus3.cmd_valid = 1; bus3.cmd_addr = 32'h0000_2008; bus3.pready = 1;
        tick();
        bus3.cmd_valid = 0;
        chk("hit3_setup_psel", bus3.psel, 3'b100);
        tick(); tick();
        chk("hit3_rsp_err", bus3.rsp_err, 0);
        chk("hit3_rsp_valid", bus3.rsp_valid, 1);
        tick();

        // Reset in ACCESS aborts asynchronously
        bus4.cmd_valid = 1; bus4.cmd_write = 1; bus4.cmd_addr = 32'h0000_1008;
        bus4.cmd_wdata = 32'hCAFE_F00D; bus4.cmd_strb = 4'h5; bus4.pready = 0;
        tick();
        bus4.cmd_valid = 0;
        tick();
        chk("ar_pre_penable", bus4.penable, 1);
        #2 preset_n = 1'b0;
        #1;
        chk("ar_state",     state4, IDLE);
        chk("ar_psel",      bus4.psel, 0);
        chk("ar_penable",   bus4.penable, 0);
        chk("ar_paddr",     bus4.paddr, 0);
        chk("ar_pwdata",    bus4.pwdata, 0);
        chk("ar_pstrb",     bus4.pstrb, 0);
        chk("ar_pwrite",    bus4.pwrite, 0);
        chk("ar_cmd_ready", bus4.cmd_ready, 1);
        chk("ar_rsp_valid", bus4.rsp_valid, 0);
        tick();
        preset_n = 1'b1;
        tick();
        chk("ar_no_rsp", bus4.rsp_valid, 0);

        // Next command after reset behaves normally
        bus4.cmd_valid = 1; bus4.cmd_write = 1; bus4.cmd_addr = 32'h0000_0004;
        bus4.cmd_wdata = 32'h0000_00A5; bus4.cmd_strb = 4'h1; bus4.pready = 1;
        tick();
        bus4.cmd_valid = 0;
        chk("post_setup_psel",  bus4.psel, 4'b0001);
        chk("post_setup_pstrb", bus4.pstrb, 4'h1);
        tick();
        chk("post_acc_pwdata", bus4.pwdata, 32'h0000_00A5);
        tick();
        chk("post_rsp_valid", bus4.rsp_valid, 1);
        chk("post_rsp_err",   bus4.rsp_err, 0);
        tick();
        chk("post_idle", state4, IDLE);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/apb_master_mux.md
Name: apb_master_mux

Overview:
Parametrised APB4 requester, the successor to the single-slave fixed-address master. It takes transfers from a valid/ready command channel, decodes the target slave from the upper address bits and drives NUM_SLAVES psel lines. It runs the SETUP/ACCESS protocol with wait states, and returns read data and error status on a valid/ready response channel. Errors come from pslverr, from a decode miss, or from a programmable pready timeout. It sits between the test/bus-bridge logic and the APB slave fabric.

Parameters:
ADDR_W, 32, paddr/cmd_addr width
DATA_W, 32, pwdata/prdata width; must be 8, 16 or 32
NUM_SLAVES, 4, number of psel lines, 1..16
SLV_SHIFT, 12, slave index = cmd_addr[SLV_SHIFT +: $clog2(NUM_SLAVES) (min 1)]
TIMEOUT, 16, max ACCESS cycles without pready before abort; 0 disables timeout

Ports:
pclk  in  1  APB clock
preset_n  in  1  async active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  byte address
cmd_wdata  in  DATA_W  write data
cmd_strb  in  DATA_W/8  write byte strobes
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when valid&ready
rsp_rdata  out  DATA_W  read data (0 for writes/errors)
rsp_err  out  1  pslverr, decode miss or timeout
rsp_timeout  out  1  error cause was timeout
psel  out  NUM_SLAVES  one-hot slave select
penable  out  1  ACCESS phase
paddr  out  ADDR_W  transfer address
pwrite  out  1  transfer direction
pwdata  out  DATA_W  write data
pstrb  out  DATA_W/8  byte strobes
prdata  in  DATA_W  mux'd read data from selected slave
pready  in  1  mux'd ready
pslverr  in  1  mux'd error

Behaviour:
- Clock and reset: one clock pclk; reset preset_n is asynchronous, active-low.
- Reset: state=IDLE; cmd_ready=1; rsp_valid, rsp_err, rsp_timeout, psel, penable, pwrite = 0; paddr, pwdata, pstrb, rsp_rdata = 0.
- Reset mid-transfer aborts immediately. No response is produced for the aborted command.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, register write, addr, wdata, strb and the decoded index.
  - Index < NUM_SLAVES -> SETUP.
  - Index >= NUM_SLAVES (decode miss) -> RESP with err=1, timeout=0, rdata=0. No APB activity.
- SETUP (1 cycle): psel[idx]=1, penable=0, paddr/pwrite/pwdata/pstrb from registers -> ACCESS.
- ACCESS:
  - psel[idx]=1, penable=1; address, data and control held stable. A wait counter increments each cycle.
  - pready=1 -> RESP; rdata = read ? prdata : 0; err = pslverr.
  - pready=0 and counter == TIMEOUT-1 (TIMEOUT != 0) -> RESP with err=1, timeout=1, rdata=0. psel/penable drop the next cycle.
  - pready takes priority over a timeout in the same cycle.
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready.
  - On rsp_valid & rsp_ready -> IDLE.
  - cmd_ready=0 until back in IDLE; no command overlap.
- Outside SETUP/ACCESS: psel=0, penable=0, paddr=0, pwdata=0, pstrb=0.
- Reads always drive pstrb=0 and pwdata=0 (APB4 rule).
- Latency: accept cycle -> SETUP -> ACCESS(n>=1) -> RESP. Minimum 3 cycles from accept to rsp_valid. Minimum 4 cycles per transfer with rsp_ready tied high.
- Wait counter width $clog2(TIMEOUT+1) (min 1); cleared on SETUP entry.
- prdata is sampled only when penable & pready.

Decomposition:
- apb_pkg: apb_state_t enum (IDLE, SETUP, ACCESS, RESP); rsp_err cause constants; a helper function for index width (max(1,$clog2(N))).
- One sub-module, apb_addr_decode: combinational cmd_addr -> index plus a miss flag. Everything else lives in apb_master_mux.

Test Plan:
- Write, no wait: cmd addr=0x1004, wdata=0xDEADBEEF, strb=0xF, pready=1 -> psel=4'b0010 for 2 cycles, penable in cycle 2, pstrb=0xF; rsp_valid 3 cycles after accept; err=0.
- Read with 3 wait states: addr=0x3010, prdata=0x12345678 on pready -> psel[3] held 5 cycles; paddr stable; rsp_rdata=0x12345678; pstrb=0 throughout.
- pslverr: read addr=0x0000, pready=1 with pslverr=1 -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- Timeout: TIMEOUT=16, pready held 0 -> exactly 16 ACCESS cycles, then rsp_err=1, rsp_timeout=1; psel=0 next cycle.
- Decode miss: NUM_SLAVES=3, addr=0x3000 -> no psel pulse; rsp_valid 1 cycle after accept with err=1.
- Backpressure and reset: rsp_ready=0 for 5 cycles -> rsp fields stable, cmd_ready=0. Separately, assert preset_n=0 in ACCESS -> all outputs return to reset values asynchronously; next command behaves normally.
